// File: rtl/servo_pkg.sv
// Shared servo PWM types, default timing constants and the saturating width function.
// Latency: none (declarations only); backpressure: not applicable.
package servo_pkg;

    typedef enum logic [0:0] {
        PARADO  = 1'b0,
        GERANDO = 1'b1
    } estado_t;

    // Defaults for a 50 MHz clock: 20 ms period, 1 ms minimum pulse.
    localparam int unsigned CICLOS_PERIODO_PADRAO = 1000000;
    localparam int unsigned LARGURA_MIN_PADRAO    = 50000;
    localparam int unsigned LARGURA_PASSO_PADRAO  = 7000;
    localparam int unsigned W_PADRAO              = 20;

    // Clamping to the period keeps the result inside W bits and still drives pwm high all period.
    function automatic int unsigned largura(
        input int unsigned p,
        input int unsigned minimo,
        input int unsigned passo,
        input int unsigned ciclos
    );
        int unsigned l;
        l = minimo + p * passo;
        if (l >= ciclos) begin
            l = ciclos;
        end
        return l;
    endfunction

endpackage

// File: rtl/contador_periodo_m.sv
// Mod-CICLOS_PERIODO counter with clear/enable and a registered strobe on its last count.
// Latency: count and strobe registered, 1 cycle; backpressure: none, habilita simply freezes it.
module contador_periodo_m #(
    parameter int unsigned CICLOS_PERIODO = servo_pkg::CICLOS_PERIODO_PADRAO,
    parameter int unsigned W              = servo_pkg::W_PADRAO
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         limpa,
    input  logic         habilita,
    output logic [W-1:0] contador_prox,
    output logic         fim
);

    localparam logic [W-1:0] ULTIMO = W'(CICLOS_PERIODO - 1);

    logic [W-1:0] contador_q, contador_d;
    logic         fim_q, fim_d;

    always_comb begin
        contador_d = contador_q;
        if (limpa) begin
            contador_d = '0;
        end else if (habilita) begin
            contador_d = (contador_q == ULTIMO) ? '0 : contador_q + 1'b1;
        end
        fim_d = !limpa && habilita && (contador_d == ULTIMO);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            contador_q <= '0;
            fim_q      <= 1'b0;
        end else begin
            contador_q <= contador_d;
            fim_q      <= fim_d;
        end
    end

    assign contador_prox = contador_d;
    assign fim           = fim_q;

endmodule

// File: rtl/controle_servo_pwm.sv
// Servo PWM: width latched from posicao at period start, pwm/fim_periodo registered (1 cycle).
// Backpressure: none; ligado=0 idles at once. SERVO_PWM_DEBUG_EN adds db_largura/db_estado.
module controle_servo_pwm #(
    parameter int unsigned N              = 3,
    parameter int unsigned CICLOS_PERIODO = servo_pkg::CICLOS_PERIODO_PADRAO,
    parameter int unsigned LARGURA_MIN    = servo_pkg::LARGURA_MIN_PADRAO,
    parameter int unsigned LARGURA_PASSO  = servo_pkg::LARGURA_PASSO_PADRAO,
    parameter int unsigned W              = servo_pkg::W_PADRAO
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ligado,
    input  logic [N-1:0] posicao,
    output logic         pwm,
    output logic         fim_periodo
`ifdef SERVO_PWM_DEBUG_EN
    ,
    output logic [W-1:0] db_largura,
    output logic [0:0]   db_estado
`endif
);

    import servo_pkg::*;

    estado_t      estado_q, estado_d;
    logic [W-1:0] largura_q, largura_d;
    logic         pwm_q, pwm_d;
    logic [W-1:0] largura_posicao;
    logic [W-1:0] contador_prox;
    logic         limpa, habilita, fim;

    assign largura_posicao = W'(largura(32'(posicao), LARGURA_MIN, LARGURA_PASSO, CICLOS_PERIODO));

    contador_periodo_m #(
        .CICLOS_PERIODO(CICLOS_PERIODO),
        .W             (W)
    ) u_contador (
        .clock        (clock),
        .reset        (reset),
        .limpa        (limpa),
        .habilita     (habilita),
        .contador_prox(contador_prox),
        .fim          (fim)
    );

    always_comb begin
        estado_d  = estado_q;
        largura_d = largura_q;
        limpa     = 1'b1;
        habilita  = 1'b0;
        case (estado_q)
            PARADO: begin
                if (ligado) begin
                    estado_d  = GERANDO;
                    largura_d = largura_posicao;
                end
            end
            GERANDO: begin
                // A deassert on the wrap edge wins: no relatch, counter cleared.
                if (!ligado) begin
                    estado_d = PARADO;
                end else begin
                    limpa    = 1'b0;
                    habilita = 1'b1;
                    if (fim) begin
                        largura_d = largura_posicao;
                    end
                end
            end
            default: estado_d = PARADO;
        endcase
        pwm_d = (estado_d == GERANDO) && (contador_prox < largura_d);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q  <= PARADO;
            largura_q <= W'(LARGURA_MIN);
            pwm_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            largura_q <= largura_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm         = pwm_q;
    assign fim_periodo = fim;

`ifdef SERVO_PWM_DEBUG_EN
    assign db_largura = largura_q;
    assign db_estado  = estado_q;
`endif

endmodule

// File: tb/tb_controle_servo_pwm.sv
// Directed bench for controle_servo_pwm with a short 20-cycle period.
module tb_controle_servo_pwm;

    logic       clock = 1'b0;
    logic       reset, ligado, ligado_sat;
    logic [2:0] posicao_tb, posicao, posicao_malha, posicao_sat;
    logic       pwm, fim_periodo, pwm_sat, fim_sat;
    logic       modo_malha, limpa_malha, subindo;
    int         vetores = 0;
    int         erros   = 0;

    always #5 clock = ~clock;

    assign posicao = modo_malha ? posicao_malha : posicao_tb;

    controle_servo_pwm #(
        .N(3), .CICLOS_PERIODO(20), .LARGURA_MIN(4), .LARGURA_PASSO(2), .W(5)
    ) dut (
        .clock(clock), .reset(reset), .ligado(ligado), .posicao(posicao),
        .pwm(pwm), .fim_periodo(fim_periodo)
    );

    controle_servo_pwm #(
        .N(3), .CICLOS_PERIODO(20), .LARGURA_MIN(4), .LARGURA_PASSO(3), .W(5)
    ) dut_sat (
        .clock(clock), .reset(reset), .ligado(ligado_sat), .posicao(posicao_sat),
        .pwm(pwm_sat), .fim_periodo(fim_sat)
    );

    // Up/down position counter (M=14, N=3) advanced by fim_periodo: 0..7 then 6..1.
    always @(posedge clock) begin
        if (limpa_malha) begin
            posicao_malha <= 3'd0;
            subindo       <= 1'b1;
        end else if (fim_periodo) begin
            if (subindo) begin
                if (posicao_malha == 3'd7) begin
                    posicao_malha <= 3'd6;
                    subindo       <= 1'b0;
                end else begin
                    posicao_malha <= posicao_malha + 3'd1;
                end
            end else begin
                if (posicao_malha == 3'd1) begin
                    posicao_malha <= 3'd0;
                    subindo       <= 1'b1;
                end else begin
                    posicao_malha <= posicao_malha - 3'd1;
                end
            end
        end
    end

    task automatic esperar_fim(input bit sat, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if ((sat ? fim_sat : fim_periodo) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; ligado = 1'b0; ligado_sat = 1'b0;
        posicao_tb = 3'd3; posicao_sat = 3'd7;
        modo_malha = 1'b0; limpa_malha = 1'b1;
        repeat (2) @(negedge clock);
        vetores += 4;
        if (pwm !== 1'b0) begin erros++; $display("FAIL reset_pwm: got %b expected 0", pwm); end
        if (fim_periodo !== 1'b0) begin erros++; $display("FAIL reset_fim: got %b expected 0", fim_periodo); end
        if (pwm_sat !== 1'b0) begin erros++; $display("FAIL reset_pwm_sat: got %b expected 0", pwm_sat); end
        if (fim_sat !== 1'b0) begin erros++; $display("FAIL reset_fim_sat: got %b expected 0", fim_sat); end
    endtask

    task automatic test_periodo_basico();
        logic ep, ef;
        reset = 1'b1; ligado = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clock);
            ep = ((j % 20) < 10);
            ef = ((j % 20) == 19);
            vetores += 2;
            if (pwm !== ep) begin erros++; $display("FAIL basico_pwm[%0d]: got %b expected %b", j, pwm, ep); end
            if (fim_periodo !== ef) begin erros++; $display("FAIL basico_fim[%0d]: got %b expected %b", j, fim_periodo, ef); end
        end
    endtask

    task automatic test_mudanca_posicao();
        bit ok;
        logic ep, ef;
        esperar_fim(1'b0, ok);
        vetores++;
        if (!ok) begin erros++; $display("FAIL mudanca_sync: got no fim_periodo expected one within 40 cycles"); end
        for (int j = 0; j < 40; j++) begin
            @(negedge clock);
            ep = (j < 20) ? (j < 10) : ((j - 20) < 18);
            ef = ((j % 20) == 19);
            vetores += 2;
            if (pwm !== ep) begin erros++; $display("FAIL mudanca_pwm[%0d]: got %b expected %b", j, pwm, ep); end
            if (fim_periodo !== ef) begin erros++; $display("FAIL mudanca_fim[%0d]: got %b expected %b", j, fim_periodo, ef); end
            if (j == 4) posicao_tb = 3'd7;
        end
        posicao_tb = 3'd3;
    endtask

    task automatic test_saturacao();
        bit ok;
        logic ef;
        ligado_sat = 1'b1;
        esperar_fim(1'b1, ok);
        vetores++;
        if (!ok) begin erros++; $display("FAIL sat_sync: got no fim_periodo expected one within 40 cycles"); end
        for (int j = 0; j < 40; j++) begin
            @(negedge clock);
            ef = ((j % 20) == 19);
            vetores += 2;
            if (pwm_sat !== 1'b1) begin erros++; $display("FAIL sat_pwm[%0d]: got %b expected 1", j, pwm_sat); end
            if (fim_sat !== ef) begin erros++; $display("FAIL sat_fim[%0d]: got %b expected %b", j, fim_sat, ef); end
        end
        ligado_sat = 1'b0;
    endtask

    task automatic test_desliga();
        bit ok;
        logic ep, ef;
        esperar_fim(1'b0, ok);
        vetores++;
        if (!ok) begin erros++; $display("FAIL desliga_sync: got no fim_periodo expected one within 40 cycles"); end
        for (int j = 0; j < 6; j++) begin
            @(negedge clock);
            vetores++;
            if (pwm !== 1'b1) begin erros++; $display("FAIL desliga_pre_pwm[%0d]: got %b expected 1", j, pwm); end
        end
        ligado = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clock);
            vetores += 2;
            if (pwm !== 1'b0) begin erros++; $display("FAIL desliga_pwm[%0d]: got %b expected 0", k, pwm); end
            if (fim_periodo !== 1'b0) begin erros++; $display("FAIL desliga_fim[%0d]: got %b expected 0", k, fim_periodo); end
        end
        ligado = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clock);
            ep = (j < 10);
            ef = (j == 19);
            vetores += 2;
            if (pwm !== ep) begin erros++; $display("FAIL religa_pwm[%0d]: got %b expected %b", j, pwm, ep); end
            if (fim_periodo !== ef) begin erros++; $display("FAIL religa_fim[%0d]: got %b expected %b", j, fim_periodo, ef); end
        end
    endtask

    task automatic test_reset_meio_pulso();
        bit ok;
        logic ep, ef;
        posicao_tb = 3'd5;
        esperar_fim(1'b0, ok);
        vetores++;
        if (!ok) begin erros++; $display("FAIL rst_meio_sync: got no fim_periodo expected one within 40 cycles"); end
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            vetores++;
            if (pwm !== 1'b1) begin erros++; $display("FAIL rst_meio_pre_pwm[%0d]: got %b expected 1", j, pwm); end
        end
        reset = 1'b0;
        @(negedge clock);
        vetores += 2;
        if (pwm !== 1'b0) begin erros++; $display("FAIL rst_meio_pwm: got %b expected 0", pwm); end
        if (fim_periodo !== 1'b0) begin erros++; $display("FAIL rst_meio_fim: got %b expected 0", fim_periodo); end
        reset = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clock);
            ep = (j < 14);
            ef = (j == 19);
            vetores += 2;
            if (pwm !== ep) begin erros++; $display("FAIL rst_pos_pwm[%0d]: got %b expected %b", j, pwm, ep); end
            if (fim_periodo !== ef) begin erros++; $display("FAIL rst_pos_fim[%0d]: got %b expected %b", j, fim_periodo, ef); end
        end
    endtask

    task automatic test_malha_fechada();
        bit ok;
        int cont;
        int larguras[14] = '{4, 6, 8, 10, 12, 14, 16, 18, 16, 14, 12, 10, 8, 6};
        ligado = 1'b0;
        limpa_malha = 1'b1;
        @(negedge clock);
        limpa_malha = 1'b0;
        modo_malha = 1'b1;
        ligado = 1'b1;
        esperar_fim(1'b0, ok);
        vetores++;
        if (!ok) begin erros++; $display("FAIL malha_sync: got no fim_periodo expected one within 40 cycles"); end
        for (int k = 0; k < 14; k++) begin
            cont = 0;
            for (int j = 0; j < 20; j++) begin
                @(negedge clock);
                if (pwm === 1'b1) cont++;
            end
            vetores += 2;
            if (fim_periodo !== 1'b1) begin erros++; $display("FAIL malha_fim[%0d]: got %b expected 1", k, fim_periodo); end
            if (cont != larguras[k]) begin erros++; $display("FAIL malha_largura[%0d]: got %0d cycles expected %0d", k, cont, larguras[k]); end
        end
        modo_malha = 1'b0;
    endtask

    initial begin
        test_reset();
        test_periodo_basico();
        test_mudanca_posicao();
        test_saturacao();
        test_desliga();
        test_reset_meio_pulso();
        test_malha_fechada();
        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
